axis_gated_fifo: RTL and testbench
==================================

// Module: axis_gated_fifo
// PURPOSE
//  Parametrised AXI4-Stream FIFO with a built-in output release gate, replacing the external
//  tready-masking glue around the stock FIFO. Buffers DEPTH beats of {tdata,tkeep,tlast,tuser}
//  in inferred RAM. Pops to the master side only after release_req plus RELEASE_DLY cycles.
//  Closes the gate again only on a packet boundary. Sits between a stream source and a consumer.
// PARAMETERS
//  DATA_W       32    tdata width, multiple of 8
//  KEEP_W       DATA_W/8  tkeep width
//  USER_W       1     tuser width, >=1
//  DEPTH        1024  storage beats; power of 2, >=4
//  RELEASE_DLY  2     cycles from release_req rise to first pop; 0..255
// PORTS
//  aclk           in   1          single clock
//  aresetn        in   1          asynchronous active-low reset
//  s_axis_tvalid  in   1          slave valid
//  s_axis_tready  out  1          slave ready (= !full)
//  s_axis_tdata   in   DATA_W     slave data
//  s_axis_tkeep   in   KEEP_W     slave keep
//  s_axis_tlast   in   1          slave end-of-packet
//  s_axis_tuser   in   USER_W     slave user
//  m_axis_tvalid  out  1          master valid (registered)
//  m_axis_tready  in   1          master ready
//  m_axis_tdata   out  DATA_W     master data
//  m_axis_tkeep   out  KEEP_W     master keep
//  m_axis_tlast   out  1          master end-of-packet
//  m_axis_tuser   out  USER_W     master user
//  release_req    in   1          level: 1 = open output gate, 0 = close at next boundary
//  gate_open      out  1          1 while FSM in OPEN or CLOSING
//  fill_level     out  clog2(DEPTH)+1  beats held in RAM plus output register
// BEHAVIOUR
//  Reset: all outputs 0 except s_axis_tready=0 during reset, 1 on first cycle after release;
//   pointers, counters, FSM=CLOSED cleared asynchronously.
//  Write: s_tvalid&s_tready stores one beat. full when RAM count==DEPTH.
//  Pop: RAM->output register when gate permits, RAM non-empty, and (out reg empty or m handshake).
//  m_axis_tvalid=1 one cycle after the pop. Held stable until m_tvalid&m_tready (AXIS rule).
//  Min latency, write to m_tvalid with gate OPEN: 2 cycles.
//  Gate FSM:
//   CLOSED->DELAY on release_req=1; counter loads RELEASE_DLY.
//   RELEASE_DLY=0: CLOSED->OPEN directly.
//   DELAY: count down; at 0 ->OPEN. release_req=0 in DELAY ->CLOSED, no pop issued.
//   OPEN: pops allowed. release_req=0: ->CLOSED if last popped beat had tlast or nothing popped
//    since OPEN, else ->CLOSING.
//   CLOSING: pops allowed until a beat with tlast is popped, then ->CLOSED.
//    release_req=1 in CLOSING ->OPEN.
//  Beat already in output register always completes regardless of gate state.
//  Simultaneous write+pop: fill_level unchanged. Pointers wrap modulo DEPTH (extra MSB for full).
//  fill_level saturates at DEPTH+1 (RAM full + out reg).
// CONFIGURATION
//  AXGF_PKT_MODE_EN defined: store-and-forward.
//   Pop only when pkt_cnt>0 (pkt_cnt++ on written tlast, -- on popped tlast; same-cycle nets 0).
//   If RAM full with pkt_cnt==0: forced cut-through until next tlast popped, so no deadlock.
//  AXGF_PKT_MODE_EN undefined: cut-through; pkt_cnt logic absent.
// STRUCTURE
//  Package axis_gated_fifo_pkg: gate FSM state enum {CLOSED,DELAY,OPEN,CLOSING},
//   beat struct/width constant helper, PTR_W function.
//  Sub-module axis_gated_fifo_ram: simple dual-port, 1 write/1 read port, registered read, no reset.
// TESTING
//  T1 release_req=0, write 8 beats -> m_tvalid stays 0, fill_level=8, s_tready=1.
//  T2 from T1, release_req=1 (RELEASE_DLY=2), m_tready=1 -> first m_tvalid 2+2 cycles later;
//   data 0..7 in order, tlast on beat 7.
//  T3 drop release_req mid-packet (beat 3 of 8) -> beats 4..7 still delivered, then CLOSED;
//   next packet held.
//  T4 fill DEPTH=16 with m_tready=0 -> s_tready=0 after 17 beats total; one pop reasserts
//   s_tready next cycle.
//  T5 random m_tready toggling -> no tdata change while m_tvalid&!m_tready; no loss/dup.
//  T6 (AXGF_PKT_MODE_EN) 5-beat packet, tlast withheld -> no m_tvalid. Send tlast -> packet
//   flows. Oversized 20-beat packet in DEPTH=16 -> forced cut-through, all 20 delivered.
//  T7 aresetn low mid-packet -> m_tvalid=0 immediately, fill_level=0, FSM CLOSED.

Source files
------------

// File: rtl/axis_gated_fifo_pkg.sv
// Shared types and helpers for axis_gated_fifo.
//  gate_st_e : output release gate states
//  ptr_w     : address width for a power-of-2 depth
//  beat_w    : stored beat width {tdata,tkeep,tlast,tuser}
package axis_gated_fifo_pkg;
  typedef enum logic [1:0] {CLOSED, DELAY, OPEN, CLOSING} gate_st_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int beat_w(input int data_w, input int keep_w, input int user_w);
    return data_w + keep_w + 1 + user_w;
  endfunction
endpackage

// File: rtl/axis_gated_fifo_if.sv
// AXI4-Stream bundle for axis_gated_fifo.
//  master : drives tvalid/tdata/tkeep/tlast/tuser, samples tready
//  slave  : samples tvalid/tdata/tkeep/tlast/tuser, drives tready
interface axis_gated_fifo_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W/8,
  parameter int USER_W = 1
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_gated_fifo_ram.sv
// Simple dual-port beat store: one write port, one read port with a
// registered read that only updates on re_i, so rdata_o holds the most
// recently read beat. No reset on the array or read register.
//  clk_i            clock
//  we_i/waddr_i/wdata_i  write port
//  re_i/raddr_i     read request
//  rdata_o          registered read data
module axis_gated_fifo_ram import axis_gated_fifo_pkg::*; #(
  parameter int W     = 38,
  parameter int DEPTH = 1024,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/axis_gated_fifo.sv
// AXI4-Stream FIFO with an output release gate.
// Beats are popped to the master side only while the gate is open; the gate
// opens RELEASE_DLY cycles after release_req rises and only closes on a
// packet boundary. The RAM read register doubles as the output register.
// Optional build macro AXGF_PKT_MODE_EN: store-and-forward (pop only once a
// whole packet is buffered, with forced cut-through when the RAM fills
// without a complete packet).
//  aclk, aresetn  clock, async active-low reset
//  s_axis         slave stream in (tready = !full)
//  m_axis         master stream out (tvalid registered)
//  release_req    level request to open the gate
//  gate_open      gate is OPEN or CLOSING
//  fill_level     beats in RAM plus output register
module axis_gated_fifo import axis_gated_fifo_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int KEEP_W      = DATA_W/8,
  parameter int USER_W      = 1,
  parameter int DEPTH       = 1024,
  parameter int RELEASE_DLY = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_gated_fifo_if.slave       s_axis,
  axis_gated_fifo_if.master      m_axis,
  input  logic                   release_req,
  output logic                   gate_open,
  output logic [$clog2(DEPTH):0] fill_level
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int BW    = beat_w(DATA_W, KEEP_W, USER_W);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;
  } beat_t;

  beat_t          wbeat, rbeat;
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q, count;
  logic           m_vld_q, full, empty, wr_en, pop, gate_ok, pkt_ok;
  gate_st_e       st_q;
  logic [7:0]     dly_q;
  logic           gate_open_q, popped_q;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = s_axis.tvalid & s_axis.tready;
  assign wbeat = '{s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};

  // rbeat always holds the last popped beat, so rbeat.tlast tells whether
  // the stream is sitting on a packet boundary. OPEN stops popping in the
  // cycle release_req drops so the close decision sees a settled rbeat;
  // CLOSING stops once the popped beat carries tlast.
  always_comb begin
    gate_ok = 1'b0;
    case (st_q)
      OPEN:    gate_ok = release_req;
      CLOSING: gate_ok = ~rbeat.tlast;
      default: gate_ok = 1'b0;
    endcase
  end

  assign pop = gate_ok & ~empty & pkt_ok & (~m_vld_q | m_axis.tready);

`ifdef AXGF_PKT_MODE_EN
  logic [PTR_W:0] pkt_cnt_q, pkt_eff;
  logic           pop_d1_q, force_q, last_out;

  // A popped tlast is only visible a cycle later in rbeat; discount it
  // immediately so the next pop cannot start an incomplete packet.
  assign last_out = pop_d1_q & rbeat.tlast;
  assign pkt_eff  = pkt_cnt_q - {{PTR_W{1'b0}}, last_out};
  assign pkt_ok   = (pkt_eff != '0) | (force_q & ~last_out);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q <= '0;
      pop_d1_q  <= 1'b0;
      force_q   <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_eff + {{PTR_W{1'b0}}, wr_en & s_axis.tlast};
      pop_d1_q  <= pop;
      // RAM full with no complete packet: stream it out to avoid deadlock.
      if (full && pkt_eff == '0) force_q <= 1'b1;
      else if (last_out)         force_q <= 1'b0;
    end
  end
`else
  assign pkt_ok = 1'b1;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      m_vld_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop)                m_vld_q <= 1'b1;
      else if (m_axis.tready) m_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_q        <= CLOSED;
      dly_q       <= '0;
      gate_open_q <= 1'b0;
      popped_q    <= 1'b0;
    end else begin
      case (st_q)
        CLOSED: if (release_req) begin
          popped_q <= 1'b0;
          if (RELEASE_DLY == 0) begin
            st_q        <= OPEN;
            gate_open_q <= 1'b1;
          end else begin
            st_q  <= DELAY;
            dly_q <= 8'(RELEASE_DLY);
          end
        end
        DELAY: begin
          if (!release_req) st_q <= CLOSED;
          else if (dly_q == 8'd1) begin
            st_q        <= OPEN;
            gate_open_q <= 1'b1;
          end else dly_q <= dly_q - 8'd1;
        end
        OPEN: begin
          if (pop) popped_q <= 1'b1;
          if (!release_req) begin
            if (!popped_q || rbeat.tlast) begin
              st_q        <= CLOSED;
              gate_open_q <= 1'b0;
            end else st_q <= CLOSING;
          end
        end
        CLOSING: begin
          if (release_req) st_q <= OPEN;
          else if (rbeat.tlast) begin
            st_q        <= CLOSED;
            gate_open_q <= 1'b0;
          end
        end
        default: begin
          st_q        <= CLOSED;
          gate_open_q <= 1'b0;
        end
      endcase
    end
  end

  axis_gated_fifo_ram #(.W(BW), .DEPTH(DEPTH)) u_ram (
    .clk_i   (aclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[PTR_W-1:0]),
    .wdata_i (wbeat),
    .re_i    (pop),
    .raddr_i (rd_ptr_q[PTR_W-1:0]),
    .rdata_o (rbeat)
  );

  // Data outputs read as zero while no beat is presented.
  assign s_axis.tready = aresetn & ~full;
  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tdata  = m_vld_q ? rbeat.tdata : '0;
  assign m_axis.tkeep  = m_vld_q ? rbeat.tkeep : '0;
  assign m_axis.tlast  = m_vld_q & rbeat.tlast;
  assign m_axis.tuser  = m_vld_q ? rbeat.tuser : '0;
  assign gate_open     = gate_open_q;
  assign fill_level    = count + {{PTR_W{1'b0}}, m_vld_q};
endmodule

// File: tb/tb_axis_gated_fifo.sv
module tb_axis_gated_fifo;
  localparam int DEPTH = 16;
  localparam int RDLY  = 2;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } bt_t;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       release_req;
  logic       gate_open;
  logic [4:0] fill_level;

  axis_gated_fifo_if #(.DATA_W(32), .KEEP_W(4), .USER_W(1)) s_if ();
  axis_gated_fifo_if #(.DATA_W(32), .KEEP_W(4), .USER_W(1)) m_if ();

  axis_gated_fifo #(
    .DATA_W(32), .KEEP_W(4), .USER_W(1), .DEPTH(DEPTH), .RELEASE_DLY(RDLY)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .release_req (release_req),
    .gate_open   (gate_open),
    .fill_level  (fill_level)
  );

  always #5 aclk = ~aclk;

  int  n_chk = 0;
  int  n_fail = 0;
  bit  s_hs, m_hs;
  bt_t exp_q[$];
  bt_t got_q[$];

  // Records handshakes seen just before the edge, then advances one cycle.
  task automatic tick();
    s_hs = s_if.tvalid && s_if.tready;
    m_hs = m_if.tvalid && m_if.tready;
    if (s_hs) exp_q.push_back({s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser});
    if (m_hs) got_q.push_back({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser});
    @(posedge aclk); #1;
  endtask

  task automatic send(input int n, input int base, input bit last_end, output int sent);
    int i, cur;
    i = 0; cur = -1;
    for (int c = 0; c < 40*n + 40 && i < n; c++) begin
      if (cur != i) begin
        s_if.tkeep = 4'($urandom);
        s_if.tuser = 1'($urandom);
        cur = i;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'(base + i);
      s_if.tlast  = last_end && (i == n-1);
      tick();
      if (s_hs) i++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    sent = i;
  endtask

  task automatic drain(output bit ok);
    m_if.tready = 1'b1;
    for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) tick();
    ok = (got_q.size() == exp_q.size());
  endtask

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; release_req = 1'b0;
    s_if.tvalid = 0; s_if.tdata = 0; s_if.tkeep = 0; s_if.tlast = 0; s_if.tuser = 0;
    m_if.tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_chk++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid got=%b want=0", m_if.tvalid); end
    n_chk++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_sready got=%b want=0", s_if.tready); end
    n_chk++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill got=%0d want=0", fill_level); end
    n_chk++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL reset_gate got=%b want=0", gate_open); end
    aresetn = 1'b1;
    tick();
    n_chk++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_sready got=%b want=1", s_if.tready); end
  endtask

  // T1: gate closed holds data even with a ready consumer.
  task automatic test_hold();
    int sent;
    clear_model();
    m_if.tready = 1'b1;
    send(8, 0, 1'b1, sent);
    n_chk++; if (sent != 8) begin n_fail++; $display("FAIL hold_sent got=%0d want=8", sent); end
    for (int c = 0; c < 4; c++) begin
      n_chk++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL hold_mvalid cyc=%0d got=%b want=0", c, m_if.tvalid); end
      tick();
    end
    n_chk++; if (fill_level !== 5'd8) begin n_fail++; $display("FAIL hold_fill got=%0d want=8", fill_level); end
    n_chk++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL hold_sready got=%b want=1", s_if.tready); end
  endtask

  // T2: release latency is RELEASE_DLY+2, data in order.
  task automatic test_release();
    int n;
    bit ok;
    release_req = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); n++;
      if (m_if.tvalid) break;
    end
    n_chk++; if (n != RDLY + 2) begin n_fail++; $display("FAIL release_latency got=%0d want=%0d", n, RDLY + 2); end
    drain(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL release_drain got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i] || got_q[i].d !== 32'(i) || got_q[i].l !== (i == 7))
        begin n_fail++; $display("FAIL release_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL release_fill got=%0d want=0", fill_level); end
    n_chk++; if (gate_open !== 1'b1) begin n_fail++; $display("FAIL release_gate got=%b want=1", gate_open); end
  endtask

  // T3: dropping release mid-packet finishes the packet, then holds.
  task automatic test_close_boundary();
    int sa, sb;
    release_req = 1'b0;
    repeat (3) tick();
    n_chk++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL close_idle_gate got=%b want=0", gate_open); end
    clear_model();
    send(8, 100, 1'b1, sa);
    send(8, 200, 1'b1, sb);
    n_chk++; if (sa + sb != 16) begin n_fail++; $display("FAIL close_sent got=%0d want=16", sa + sb); end
    release_req = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < 4; c++) tick();
    release_req = 1'b0;
    repeat (30) tick();
    n_chk++; if (got_q.size() != 8) begin n_fail++; $display("FAIL close_count got=%0d want=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL close_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    n_chk++; if (fill_level !== 5'd8) begin n_fail++; $display("FAIL close_fill got=%0d want=8", fill_level); end
    n_chk++; if (gate_open !== 1'b0 || m_if.tvalid !== 1'b0)
      begin n_fail++; $display("FAIL close_state gate=%b mvalid=%b want=0/0", gate_open, m_if.tvalid); end
  endtask

  // T4: fill to DEPTH+1 with a stalled consumer, one pop reopens s_tready.
  task automatic test_full();
    bit ok;
    int sent;
    release_req = 1'b1;
    drain(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL full_predrain got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_prebeat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    clear_model();
    m_if.tready = 1'b0;
    send(DEPTH + 1, 300, 1'b1, sent);
    n_chk++; if (sent != DEPTH + 1) begin n_fail++; $display("FAIL full_sent got=%0d want=%0d", sent, DEPTH + 1); end
    s_if.tvalid = 1'b1; s_if.tdata = 32'hDEAD_0999;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL full_sready cyc=%0d got=%b want=0", c, s_if.tready); end
      tick();
    end
    s_if.tvalid = 1'b0;
    n_chk++; if (exp_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL full_accepted got=%0d want=%0d", exp_q.size(), DEPTH + 1); end
    n_chk++; if (int'(fill_level) != DEPTH + 1) begin n_fail++; $display("FAIL full_fill got=%0d want=%0d", fill_level, DEPTH + 1); end
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    n_chk++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL full_reopen got=%b want=1", s_if.tready); end
    n_chk++; if (int'(fill_level) != DEPTH) begin n_fail++; $display("FAIL full_fill_after got=%0d want=%0d", fill_level, DEPTH); end
    drain(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL full_drain got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // T5: random traffic and backpressure; output stable while stalled.
  task automatic test_random_backpressure();
    bit          ok, prev_stall;
    logic [31:0] prev_d;
    int          sent;
    clear_model();
    release_req = 1'b1;
    s_hs = 1'b0; prev_stall = 1'b0; prev_d = '0;
    s_if.tvalid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      n_chk++; if (int'(fill_level) != exp_q.size() - got_q.size())
        begin n_fail++; $display("FAIL rand_fill cyc=%0d got=%0d want=%0d", c, fill_level, exp_q.size() - got_q.size()); end
      if (prev_stall) begin
        n_chk++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_d)
          begin n_fail++; $display("FAIL rand_stable cyc=%0d got=%b/%h want=1/%h", c, m_if.tvalid, m_if.tdata, prev_d); end
      end
      if (!s_if.tvalid || s_hs) begin
        s_if.tvalid = ($urandom_range(2) != 0);
        s_if.tdata  = $urandom;
        s_if.tkeep  = 4'($urandom);
        s_if.tuser  = 1'($urandom);
        s_if.tlast  = ($urandom_range(3) == 0);
      end
      m_if.tready = 1'($urandom);
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_d     = m_if.tdata;
      tick();
    end
    m_if.tready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!s_if.tvalid || s_hs) break;
      tick();
    end
    s_if.tvalid = 1'b0;
    send(1, 32'h0ABC, 1'b1, sent);
    drain(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rand_drain got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef AXGF_PKT_MODE_EN
  // T6: store-and-forward holds partial packets; oversized ones cut through.
  task automatic test_pkt_mode();
    bit ok;
    int sent;
    bit seen;
    clear_model();
    release_req = 1'b1;
    m_if.tready = 1'b1;
    send(4, 500, 1'b0, sent);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (m_if.tvalid) seen = 1'b1;
      tick();
    end
    n_chk++; if (seen || got_q.size() != 0) begin n_fail++; $display("FAIL pkt_hold got=%0d beats want=0", got_q.size()); end
    send(1, 504, 1'b1, sent);
    drain(ok);
    n_chk++; if (!ok || got_q.size() != 5) begin n_fail++; $display("FAIL pkt_flow got=%0d want=5", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pkt_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    clear_model();
    send(20, 600, 1'b1, sent);
    n_chk++; if (sent != 20) begin n_fail++; $display("FAIL pkt_big_sent got=%0d want=20", sent); end
    drain(ok);
    n_chk++; if (!ok || got_q.size() != 20) begin n_fail++; $display("FAIL pkt_big_count got=%0d want=20", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pkt_big_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask
`endif

  // T7: asynchronous reset mid-packet.
  task automatic test_reset_mid();
    int sent;
    clear_model();
    release_req = 1'b1;
    m_if.tready = 1'b0;
    send(6, 700, 1'b0, sent);
    n_chk++; if (int'(fill_level) != 6) begin n_fail++; $display("FAIL rmid_prefill got=%0d want=6", fill_level); end
    #2;
    aresetn = 1'b0;
    #1;
    n_chk++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_mvalid got=%b want=0", m_if.tvalid); end
    n_chk++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL rmid_fill got=%0d want=0", fill_level); end
    n_chk++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL rmid_gate got=%b want=0", gate_open); end
    n_chk++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL rmid_sready got=%b want=0", s_if.tready); end
    release_req = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    clear_model();
    repeat (2) tick();
    n_chk++; if (gate_open !== 1'b0 || fill_level !== 5'd0 || s_if.tready !== 1'b1)
      begin n_fail++; $display("FAIL rmid_after gate=%b fill=%0d sready=%b want=0/0/1", gate_open, fill_level, s_if.tready); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_release();
    test_close_boundary();
    test_full();
    test_random_backpressure();
`ifdef AXGF_PKT_MODE_EN
    test_pkt_mode();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
